// File: rtl/float_to_dec.sv
// float_to_dec
// Iterative IEEE-754 single-precision to decimal converter. One operand is
// split into a signed integer part (truncated toward zero) and FRAC_DIGITS
// truncated decimal fraction digits packed as an unsigned integer, e.g.
// 3.1415927 -> int_out = 3, frac_out = 1415927.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   start     request conversion of f_in (sampled only when idle)
//   f_in      IEEE-754 single operand
//   busy      high while a conversion is in progress
//   done      one-cycle pulse when the result outputs update
//   sign_out  sign bit of the converted operand
//   int_out   signed two's-complement integer part
//   frac_out  FRAC_DIGITS truncated decimal digits of the fraction
//   overflow  |value| >= 2^31, Inf or NaN
//   is_nan    operand is NaN
//
// Latency: start sampled at edge k -> done high after edge k+FRAC_DIGITS+2.
module float_to_dec #(
    parameter int FRAC_DIGITS = 7
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] f_in,
    output logic        busy,
    output logic        done,
    output logic        sign_out,
    output logic [31:0] int_out,
    output logic [31:0] frac_out,
    output logic        overflow,
    output logic        is_nan
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ALIGN = 2'd1,
        DIGIT = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [3:0] LAST_DIGIT = 4'(FRAC_DIGITS - 1);

    state_t      state_q, state_d;
    logic [31:0] op_q, op_d;
    logic [31:0] int_mag_q, int_mag_d;
    logic [31:0] frac_reg_q, frac_reg_d;
    logic [31:0] frac_acc_q, frac_acc_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        ovf_path_q, ovf_path_d;
    logic        nan_path_q, nan_path_d;

    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        sign_q, sign_d;
    logic [31:0] int_q, int_d;
    logic [31:0] frac_q, frac_d;
    logic        ovf_q, ovf_d;
    logic        nan_q, nan_d;

    // Operand fields and Q32.32 alignment of the latched operand.
    logic [7:0]  exp_f;
    logic [23:0] mant;
    logic [63:0] q_mag;
    logic        exp_ovf;
    logic        exp_nan;
    logic [35:0] prod;

    always_comb begin
        exp_f   = op_q[30:23];
        mant    = {exp_f != 8'd0, op_q[22:0]};
        exp_ovf = (exp_f >= 8'd158);
        exp_nan = (exp_f == 8'hFF) && (op_q[22:0] != 23'd0);
        q_mag   = 64'd0;
        // Value = mant * 2^(e-150); scaled by 2^32 that is mant * 2^(e-118).
        // Right shifts of 64 or more bits truncate to zero, which covers the
        // tiny-exponent cases without a separate compare.
        if (exp_f == 8'd0) begin
            q_mag = 64'd0;
        end else if (exp_f >= 8'd118) begin
            q_mag = {40'd0, mant} << (exp_f - 8'd118);
        end else begin
            q_mag = {40'd0, mant} >> (8'd118 - exp_f);
        end
        // One decimal digit falls out of the top nibble of frac*10.
        prod = {4'd0, frac_reg_q} * 36'd10;
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        int_mag_d  = int_mag_q;
        frac_reg_d = frac_reg_q;
        frac_acc_d = frac_acc_q;
        cnt_d      = cnt_q;
        ovf_path_d = ovf_path_q;
        nan_path_d = nan_path_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        sign_d     = sign_q;
        int_d      = int_q;
        frac_d     = frac_q;
        ovf_d      = ovf_q;
        nan_d      = nan_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    op_d    = f_in;
                    busy_d  = 1'b1;
                    state_d = ALIGN;
                end
            end

            ALIGN: begin
                ovf_path_d = exp_ovf;
                nan_path_d = exp_nan;
                cnt_d      = 4'd0;
                frac_acc_d = 32'd0;
                if (exp_ovf) begin
                    // Digits still iterate on zero so latency is fixed.
                    int_mag_d  = 32'd0;
                    frac_reg_d = 32'd0;
                end else begin
                    int_mag_d  = q_mag[63:32];
                    frac_reg_d = q_mag[31:0];
                end
                state_d = DIGIT;
            end

            DIGIT: begin
                frac_reg_d = prod[31:0];
                frac_acc_d = frac_acc_q * 32'd10 + {28'd0, prod[35:32]};
                if (cnt_q == LAST_DIGIT) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end

            DONE: begin
                sign_d = op_q[31];
                ovf_d  = ovf_path_q;
                nan_d  = nan_path_q;
                if (ovf_path_q) begin
                    int_d  = op_q[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
                    frac_d = 32'd0;
                end else begin
                    int_d  = op_q[31] ? (32'd0 - int_mag_q) : int_mag_q;
                    frac_d = frac_acc_q;
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            op_q       <= 32'd0;
            int_mag_q  <= 32'd0;
            frac_reg_q <= 32'd0;
            frac_acc_q <= 32'd0;
            cnt_q      <= 4'd0;
            ovf_path_q <= 1'b0;
            nan_path_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            sign_q     <= 1'b0;
            int_q      <= 32'd0;
            frac_q     <= 32'd0;
            ovf_q      <= 1'b0;
            nan_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            int_mag_q  <= int_mag_d;
            frac_reg_q <= frac_reg_d;
            frac_acc_q <= frac_acc_d;
            cnt_q      <= cnt_d;
            ovf_path_q <= ovf_path_d;
            nan_path_q <= nan_path_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            sign_q     <= sign_d;
            int_q      <= int_d;
            frac_q     <= frac_d;
            ovf_q      <= ovf_d;
            nan_q      <= nan_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign sign_out = sign_q;
    assign int_out  = int_q;
    assign frac_out = frac_q;
    assign overflow = ovf_q;
    assign is_nan   = nan_q;

endmodule

// File: doc/float_to_dec.md
# float_to_dec

Iterative IEEE-754 single-precision to decimal converter: takes one 32-bit float and produces a signed integer part plus a fixed number of truncated decimal fraction digits packed as an unsigned integer. For example, 3.1415927 becomes int 3 and frac 1415927. It is the inverse of the integer/fraction-digit to float front-end of the MAC datapath. It sits on the MAC accumulator output so results can be read back in the same integer.fraction-digit form used to load operands.

## Interface
- FRAC_DIGITS, 7: number of decimal fraction digits produced (1–9).
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request conversion of f_in. Sampled only in IDLE.
- f_in  input  32  IEEE-754 single operand.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when results update.
- sign_out  output  1  sign bit of the converted operand.
- int_out  output  32  signed two's-complement integer part, truncated toward zero.
- frac_out  output  32  unsigned; FRAC_DIGITS truncated decimal digits of the magnitude's fraction.
- overflow  output  1  |value| ≥ 2^31, Inf, or NaN.
- is_nan  output  1  operand is NaN.

## Operation
- FSM states: IDLE, ALIGN, DIGIT, DONE.
- IDLE, start=1: latch f_in, go to ALIGN; busy=1. While busy, start is ignored.
- ALIGN, one cycle:
  - Split the operand into s, e[7:0], m = {e!=0, f[22:0]}.
  - Form a 64-bit Q32.32 magnitude from m, with shift amount e−118: left shift if ≥0, right shift with truncation if <0.
  - e=0 (zero or denormal) gives magnitude 0.
  - e≥158 or e=255 sets the overflow path.
  - Load int_mag = Q[63:32], frac_reg = Q[31:0], digit counter = 0, frac accumulator = 0.
- DIGIT, one cycle per digit, FRAC_DIGITS cycles:
  - p = frac_reg×10 (36 bits).
  - digit = p[35:32]; frac_reg = p[31:0].
  - frac_acc = frac_acc×10 + digit.
  - After the last digit, go to DONE.
- DONE, one cycle, registers the outputs:
  - int_out = s ? −int_mag : int_mag.
  - frac_out = frac_acc; sign_out = s.
  - done=1, busy=0, then return to IDLE.
- Overflow handling:
  - int_out = s ? 0x80000000 : 0x7FFFFFFF, frac_out = 0, overflow=1.
  - is_nan = (e=255 && f[22:0]!=0); NaN uses s from the operand.
  - The DIGIT cycles still run, so latency stays constant.
- Negative values with |v|<1: int_out = 0, sign_out = 1, frac_out holds the digits.
- Rounding: none. Digits are truncated from the truncated 32-bit binary fraction.
- Outputs hold their last values between conversions.

## Timing
- Reset (asynchronous, rst_n=0): FSM to IDLE.
  - busy, done, sign_out, overflow, is_nan = 0.
  - int_out = 0, frac_out = 0.
  - All internal registers cleared.
- Reset mid-conversion: abort, no done pulse, outputs return to reset values.
- Let start be sampled high at edge k:
  - busy is high in cycles k..k+FRAC_DIGITS+1.
  - done is high and the outputs are valid in cycle k+FRAC_DIGITS+2 (after that edge).
  - Total latency is FRAC_DIGITS+2 cycles; with the default, done arrives 9 cycles after start.
- Back-to-back: start held high during the DONE cycle is ignored. The next accept happens at the first edge after returning to IDLE, so the minimum issue interval is FRAC_DIGITS+3 cycles.
- A start pulse shorter than one clock that misses an edge is not captured.

## Test plan
- Pi: f_in=0x40490FDB, start pulse.
  - done exactly 9 cycles later.
  - int_out=3, frac_out=1415927, sign_out=0, overflow=0.
- Exact values, one after another:
  - 0x42C80000 (100.0) gives int 100, frac 0.
  - 0x3F000000 (0.5) gives int 0, frac 5000000.
  - 0xC0100000 (−2.25) gives int −2 (0xFFFFFFFE), frac 2500000, sign_out=1.
- Negative fraction: 0xBE800000 (−0.25) gives int 0, frac 2500000, sign_out=1.
- Special values:
  - 0x501502F9 (1e10) gives overflow=1, int 0x7FFFFFFF, frac 0.
  - 0xFF800000 (−Inf) gives overflow=1, int 0x80000000.
  - 0x7FC00000 gives is_nan=1, overflow=1.
  - 0x00000001 (denormal) gives all zeros.
- Busy handling: pulse start again 3 cycles after the first accept with a different f_in. The second request is ignored, and the outputs match the first operand.
- Reset mid-conversion: drop rst_n for 1 cycle during DIGIT.
  - No done pulse; outputs go to 0 immediately.
  - A fresh start afterwards converts 0x40490FDB correctly.
